// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd tortoise/hare run controller for one bank of
// dual-copy GNR nodes. Finds transient length (mu), period (lambda) and the
// first attractor state reached from a latched initial state.
// Optional feature: define GNR_TIMEOUT_EN to bound phase 1 at MAX_ROUNDS
// rounds; without it phase 1 is unbounded and timeout stays 0.
module gnr_attractor_ctrl #(
    parameter int NUM_NOS    = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_ROUNDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_NOS-1:0] init_in,
    input  logic [NUM_NOS-1:0] s0,
    input  logic [NUM_NOS-1:0] s1,
    output logic               reset_nos,
    output logic [NUM_NOS-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   mu,
    output logic [CNT_W-1:0]   lambda,
    output logic [NUM_NOS-1:0] attr_state,
    output logic               timeout
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        P1A,
        P1B,
        P1C,
        P2A,
        P2B,
        P3R,
        P3L,
        P3C,
        P3A,
        P3B,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] RND_LIMIT = CNT_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic [NUM_NOS-1:0] init_q, init_d;
    logic [CNT_W-1:0]   rnd_q, rnd_d;
    logic [CNT_W-1:0]   mu_q, mu_d;
    logic [CNT_W-1:0]   lambda_q, lambda_d;
    logic [CNT_W-1:0]   lcnt_q, lcnt_d;
    logic [NUM_NOS-1:0] attr_q, attr_d;
    logic               timeout_q, timeout_d;
    logic               reset_nos_q, reset_nos_d;
    logic               start_s0_q, start_s0_d;
    logic               start_s1_q, start_s1_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic [CNT_W-1:0]   rnd_inc;
    logic               limit_hit;

    // Round counter increment, held once it reaches the round limit.
    assign rnd_inc = (rnd_q >= RND_LIMIT) ? rnd_q : rnd_q + CNT_W'(1);

`ifdef GNR_TIMEOUT_EN
    assign limit_hit = (rnd_inc >= RND_LIMIT);
`else
    assign limit_hit = 1'b0;
`endif

    // Next-state, counter and result update logic.
    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        rnd_d     = rnd_q;
        mu_d      = mu_q;
        lambda_d  = lambda_q;
        lcnt_d    = lcnt_q;
        attr_d    = attr_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (start && !valid_q) begin
                    init_d  = init_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rnd_d     = '0;
                mu_d      = '0;
                lambda_d  = '0;
                attr_d    = '0;
                timeout_d = 1'b0;
                state_d   = P1A;
            end
            P1A: state_d = P1B;
            P1B: state_d = P1C;
            P1C: begin
                rnd_d = rnd_inc;
                if (s0 == s1) begin
                    state_d = P2A;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    mu_d      = '0;
                    lambda_d  = '0;
                    attr_d    = '0;
                    state_d   = DONE;
                end else begin
                    state_d = P1A;
                end
            end
            P2A: state_d = P2B;
            P2B: begin
                lambda_d = lambda_q + CNT_W'(1);
                // Both copies must be reloaded before the lambda-step lead.
                state_d  = (s1 == s0) ? P3R : P2A;
            end
            P3R: begin
                lcnt_d  = lambda_q;
                state_d = P3L;
            end
            P3L: begin
                lcnt_d = lcnt_q - CNT_W'(1);
                if (lcnt_q == CNT_W'(1)) begin
                    state_d = P3C;
                end
            end
            P3C: begin
                if (s0 == s1) begin
                    attr_d  = s0;
                    state_d = DONE;
                end else begin
                    mu_d    = mu_q + CNT_W'(1);
                    state_d = P3A;
                end
            end
            P3A: state_d = P3B;
            P3B: state_d = P3C;
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and status decoded from the next state so they are registered
    // and line up with the state they belong to.
    always_comb begin
        reset_nos_d = (state_d == LOAD) || (state_d == P3R);
        start_s0_d  = (state_d == P1A) || (state_d == P1B) ||
                      (state_d == P3A) || (state_d == P3B);
        start_s1_d  = (state_d == P1A) || (state_d == P1B) ||
                      (state_d == P2A) || (state_d == P3L) ||
                      (state_d == P3A);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        valid_d     = (state_d == DONE);
    end

    // State, counters and registered outputs; reset aborts any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_q      <= '0;
            rnd_q       <= '0;
            mu_q        <= '0;
            lambda_q    <= '0;
            lcnt_q      <= '0;
            attr_q      <= '0;
            timeout_q   <= 1'b0;
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            rnd_q       <= rnd_d;
            mu_q        <= mu_d;
            lambda_q    <= lambda_d;
            lcnt_q      <= lcnt_d;
            attr_q      <= attr_d;
            timeout_q   <= timeout_d;
            reset_nos_q <= reset_nos_d;
            start_s0_q  <= start_s0_d;
            start_s1_q  <= start_s1_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign reset_nos  = reset_nos_q;
    assign init_state = init_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign res_valid  = valid_q;
    assign mu         = mu_q;
    assign lambda     = lambda_q;
    assign attr_state = attr_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Testbench for gnr_attractor_ctrl with a 4-node bank whose map is
// f(0..5)=x+1, f(6)=3, f(x>=7)=x. Build with GNR_TIMEOUT_EN to exercise
// the phase-1 round limit (MAX_ROUNDS=2).
`timescale 1ns/1ps
module tb_gnr_attractor_ctrl;

    localparam int N     = 4;
    localparam int CW    = 16;
`ifdef GNR_TIMEOUT_EN
    localparam int MAXR  = 2;
`else
    localparam int MAXR  = 1024;
`endif
    localparam int LIMIT = 2000;

    logic          clk       = 1'b0;
    logic          clk_en    = 1'b1;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          res_ready = 1'b0;
    logic [N-1:0]  init_in   = '0;
    logic [N-1:0]  s0_q      = '0;
    logic [N-1:0]  s1_q      = '0;
    logic          pass_q    = 1'b1;

    logic          reset_nos, start_s0, start_s1, busy, res_valid, timeout;
    logic [N-1:0]  init_state, attr_state;
    logic [CW-1:0] mu, lambda;

    int total = 0;
    int bad   = 0;

    gnr_attractor_ctrl #(
        .NUM_NOS   (N),
        .CNT_W     (CW),
        .MAX_ROUNDS(MAXR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_in   (init_in),
        .s0        (s0_q),
        .s1        (s1_q),
        .reset_nos (reset_nos),
        .init_state(init_state),
        .start_s0  (start_s0),
        .start_s1  (start_s1),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .mu        (mu),
        .lambda    (lambda),
        .attr_state(attr_state),
        .timeout   (timeout)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic logic [N-1:0] f(input logic [N-1:0] x);
        if (x <= 4'd5)      return x + 4'd1;
        else if (x == 4'd6) return 4'd3;
        else                return x;
    endfunction

    // Node bank: s1 steps per start_s1, s0 steps on every second start_s0.
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_q   <= init_state;
            s1_q   <= init_state;
            pass_q <= 1'b1;
        end else begin
            if (start_s1) s1_q <= f(s1_q);
            if (start_s0) begin
                pass_q <= ~pass_q;
                if (!pass_q) s0_q <= f(s0_q);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the orbit, find first repeat; meet round is the
    // smallest t>=1 with x_t == x_2t.
    task automatic model(input logic [N-1:0] init, output logic [CW-1:0] emu,
                         output logic [CW-1:0] elam, output logic [N-1:0] eattr,
                         output logic eto, output int et);
        logic [N-1:0] xs [0:63];
        int first [0:15];
        int k;
        int m;
        xs[0] = init;
        for (int i = 1; i < 64; i++) xs[i] = f(xs[i-1]);
        for (int i = 0; i < 16; i++) first[i] = -1;
        k = 0;
        while (first[xs[k]] < 0) begin
            first[xs[k]] = k;
            k++;
        end
        m  = first[xs[k]];
        et = 1;
        while (xs[et] != xs[2*et] && et < 31) et++;
        if (et > MAXR) begin
            eto = 1'b1; emu = '0; elam = '0; eattr = '0;
        end else begin
            eto = 1'b0; emu = CW'(m); elam = CW'(k - m); eattr = xs[m];
        end
    endtask

    task automatic check_results(input string tag, input logic [N-1:0] init);
        logic [CW-1:0] emu, elam;
        logic [N-1:0]  eattr;
        logic          eto;
        int            et;
        model(init, emu, elam, eattr, eto, et);
        check($sformatf("%s_mu", tag), 64'(mu), 64'(emu));
        check($sformatf("%s_lambda", tag), 64'(lambda), 64'(elam));
        check($sformatf("%s_attr", tag), 64'(attr_state), 64'(eattr));
        check($sformatf("%s_timeout", tag), 64'(timeout), 64'(eto));
    endtask

    task automatic run(input logic [N-1:0] init, input string tag);
        logic [CW-1:0] emu, elam;
        logic [N-1:0]  eattr;
        logic          eto;
        int            et;
        int n = 0, both = 0, s0only = 0, s1only = 0, resets = 0, overlap = 0;
        model(init, emu, elam, eattr, eto, et);
        @(negedge clk);
        init_in = init;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s_busy", tag), 64'(busy), 64'd1);
        while (!res_valid && n < LIMIT) begin
            if (start_s0 && start_s1)  both++;
            if (start_s0 && !start_s1) s0only++;
            if (start_s1 && !start_s0) s1only++;
            if (reset_nos) begin
                resets++;
                if (start_s0 || start_s1) overlap++;
            end
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_valid", tag), 64'(res_valid), 64'd1);
        check($sformatf("%s_busy_done", tag), 64'(busy), 64'd0);
        check_results(tag, init);
        check($sformatf("%s_both_strobes", tag), 64'(both),
              eto ? 64'(2*MAXR) : 64'(2*et + int'(emu)));
        check($sformatf("%s_s1_only", tag), 64'(s1only), eto ? 64'd0 : 64'(2*int'(elam)));
        check($sformatf("%s_s0_only", tag), 64'(s0only), eto ? 64'd0 : 64'(emu));
        check($sformatf("%s_resets", tag), 64'(resets), eto ? 64'd1 : 64'd2);
        check($sformatf("%s_overlap", tag), 64'(overlap), 64'd0);
    endtask

    task automatic finish_handshake(input string tag);
        @(negedge clk);
        check($sformatf("%s_valid_clr", tag), 64'(res_valid), 64'd0);
        check($sformatf("%s_idle_busy", tag), 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({reset_nos, init_state, start_s0, start_s1, busy, res_valid,
                    mu, lambda, attr_state, timeout});
    endfunction

    initial begin
        logic [CW-1:0] emu, elam;
        logic [N-1:0]  eattr, rinit;
        logic          eto;
        int            et, hold, n;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Case 1: transient 3, period 4
        res_ready = 1'b1;
        run(4'd0, "case1");
`ifndef GNR_TIMEOUT_EN
        check("case1_mu_lit", 64'(mu), 64'd3);
        check("case1_lambda_lit", 64'(lambda), 64'd4);
        check("case1_attr_lit", 64'(attr_state), 64'd3);
`endif
        finish_handshake("case1");

        // Case 2: fixed point
        run(4'd9, "case2");
        check("case2_mu_lit", 64'(mu), 64'd0);
        check("case2_lambda_lit", 64'(lambda), 64'd1);
        check("case2_attr_lit", 64'(attr_state), 64'd9);
        finish_handshake("case2");

        // Case 3: starts on the cycle
        run(4'd4, "case3");
`ifndef GNR_TIMEOUT_EN
        check("case3_mu_lit", 64'(mu), 64'd0);
        check("case3_lambda_lit", 64'(lambda), 64'd4);
        check("case3_attr_lit", 64'(attr_state), 64'd4);
`endif
        finish_handshake("case3");

        // Case 4: back-pressure holds the result, start ignored meanwhile
        res_ready = 1'b0;
        run(4'd0, "case4");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                init_in = 4'd9;
                start   = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check("case4_hold_valid", 64'(res_valid), 64'd1);
            check("case4_hold_busy", 64'(busy), 64'd0);
            check_results("case4_hold", 4'd0);
        end
        res_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("case4_release_valid", 64'(res_valid), 64'd0);
        check("case4_release_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("case4_no_restart_busy", 64'(busy), 64'd0);
        check("case4_no_restart_load", 64'(reset_nos), 64'd0);

        // Case 5: async reset during phase 2, clock stopped
        @(negedge clk);
        init_in = 4'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(start_s1 && !start_s0 && !reset_nos) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("case5_reach_phase2", 64'(n < LIMIT), 64'd1);
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("case5_reset_now", all_outs(), 64'd0);
        #20 check("case5_reset_stopped", all_outs(), 64'd0);
        check("case5_clk_stopped", 64'(clk), 64'd0);
        rst_n = 1'b1;
        #2 clk_en = 1'b1;
        run(4'd0, "case5_rerun");
        finish_handshake("case5_rerun");

        // Case 6: round limit (timeout build) or plain case 1 result
        run(4'd0, "case6");
`ifdef GNR_TIMEOUT_EN
        check("case6_timeout_lit", 64'(timeout), 64'd1);
        check("case6_mu_lit", 64'(mu), 64'd0);
        check("case6_lambda_lit", 64'(lambda), 64'd0);
`else
        check("case6_timeout_lit", 64'(timeout), 64'd0);
        check("case6_mu_lit", 64'(mu), 64'd3);
        check("case6_lambda_lit", 64'(lambda), 64'd4);
`endif
        finish_handshake("case6");

        // Randomized initial states and result back-pressure
        for (int r = 0; r < 12; r++) begin
            rinit     = N'($urandom_range(0, 15));
            hold      = int'($urandom_range(0, 3));
            res_ready = (hold == 0);
            run(rinit, $sformatf("rand%0d_init%0d", r, rinit));
            if (hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    check("rand_hold_valid", 64'(res_valid), 64'd1);
                end
                res_ready = 1'b1;
            end
            finish_handshake("rand");
        end

        model(4'd0, emu, elam, eattr, eto, et);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
